// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared state type, width helpers and counter widths for param_dcache
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FETCH
    } state_t;

    localparam int HIT_CNT_W  = 32;
    localparam int MISS_CNT_W = 32;
    localparam int WB_CNT_W   = 16;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) width = i + 1;
        end
        return width;
    endfunction

    function automatic int tag_width(input int addr_w, input int lines, input int words);
        return addr_w - clog2(lines) - clog2(words);
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// rtl/dcache_line_store.sv - valid/dirty/tag/block arrays with one read port and one write port
module dcache_line_store
    import dcache_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int LINES  = 8,
    parameter int WORDS  = 4,
    parameter int TAG_W  = 3,
    parameter int IDX_W  = clog2(LINES),
    parameter int OFF_W  = clog2(WORDS),
    parameter int BLK_W  = WORD_W * WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_index,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [BLK_W-1:0]  rd_block,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic              word_en,
    input  logic [OFF_W-1:0]  wr_offset,
    input  logic [WORD_W-1:0] wr_word,
    input  logic              fill_en,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [BLK_W-1:0]  fill_block,
    input  logic              clean_en
);

    logic [LINES-1:0] valid;
    logic [LINES-1:0] dirty;
    logic [TAG_W-1:0] tags   [LINES];
    logic [BLK_W-1:0] blocks [LINES];

    assign rd_valid = valid[rd_index];
    assign rd_dirty = dirty[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_block = blocks[rd_index];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            dirty <= '0;
        end else if (fill_en) begin
            valid[wr_index] <= 1'b1;
            dirty[wr_index] <= 1'b0;
        end else if (word_en) begin
            dirty[wr_index] <= 1'b1;
        end else if (clean_en) begin
            dirty[wr_index] <= 1'b0;
        end
    end

    // Tag and data survive reset; only the valid bits make them unreachable.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tags[wr_index]   <= fill_tag;
            blocks[wr_index] <= fill_block;
        end else if (word_en) begin
            blocks[wr_index][int'(wr_offset)*WORD_W +: WORD_W] <= wr_word;
        end
    end

endmodule

// File: rtl/param_dcache.sv
// rtl/param_dcache.sv - direct-mapped write-back cache controller; DCACHE_PERF_EN adds perf counters
module param_dcache
    import dcache_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int ADDR_W = 8,
    parameter int LINES  = 8,
    parameter int WORDS  = 4
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic                           READ,
    input  logic                           WRITE,
    input  logic [ADDR_W-1:0]              ADDRESS,
    input  logic [WORD_W-1:0]              WRITEDATA,
    output logic [WORD_W-1:0]              READDATA,
    output logic                           BUSYWAIT,
    output logic                           mem_read,
    output logic                           mem_write,
    output logic [ADDR_W-clog2(WORDS)-1:0] mem_address,
    output logic [WORD_W*WORDS-1:0]        mem_writedata,
    input  logic [WORD_W*WORDS-1:0]        mem_readdata,
    input  logic                           mem_busywait
`ifdef DCACHE_PERF_EN
    ,
    output logic [HIT_CNT_W-1:0]           hit_count,
    output logic [MISS_CNT_W-1:0]          miss_count,
    output logic [WB_CNT_W-1:0]            wb_count
`endif
);

    localparam int OFF_W = clog2(WORDS);
    localparam int IDX_W = clog2(LINES);
    localparam int TAG_W = tag_width(ADDR_W, LINES, WORDS);
    localparam int BLK_W = WORD_W * WORDS;

    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] index;
    logic [OFF_W-1:0] offset;

    assign tag    = ADDRESS[ADDR_W-1 -: TAG_W];
    assign index  = ADDRESS[OFF_W +: IDX_W];
    assign offset = ADDRESS[OFF_W-1:0];

    state_t state, next_state;

    logic             line_valid;
    logic             line_dirty;
    logic [TAG_W-1:0] line_tag;
    logic [BLK_W-1:0] line_block;
    logic             word_en;
    logic             fill_en;
    logic             clean_en;
    logic             access;
    logic             hit;

    assign access        = READ | WRITE;
    assign hit           = line_valid && (line_tag == tag);
    assign mem_writedata = line_block;

    dcache_line_store #(
        .WORD_W (WORD_W),
        .LINES  (LINES),
        .WORDS  (WORDS),
        .TAG_W  (TAG_W)
    ) u_store (
        .clk        (CLK),
        .rst        (RESET),
        .rd_index   (index),
        .rd_valid   (line_valid),
        .rd_dirty   (line_dirty),
        .rd_tag     (line_tag),
        .rd_block   (line_block),
        .wr_index   (index),
        .word_en    (word_en),
        .wr_offset  (offset),
        .wr_word    (WRITEDATA),
        .fill_en    (fill_en),
        .fill_tag   (tag),
        .fill_block (mem_readdata),
        .clean_en   (clean_en)
    );

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= next_state;
    end

    // Every output is forced quiet while RESET is high so an aborted transfer drops at once.
    always_comb begin
        next_state  = state;
        BUSYWAIT    = 1'b0;
        READDATA    = '0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = {tag, index};
        word_en     = 1'b0;
        fill_en     = 1'b0;
        clean_en    = 1'b0;
        if (!RESET) begin
            case (state)
                IDLE: begin
                    if (access) begin
                        if (hit) begin
                            word_en = WRITE;
                            if (READ) READDATA = line_block[int'(offset)*WORD_W +: WORD_W];
                        end else begin
                            BUSYWAIT   = 1'b1;
                            next_state = (line_valid && line_dirty) ? WRITEBACK : FETCH;
                        end
                    end
                end
                WRITEBACK: begin
                    BUSYWAIT    = 1'b1;
                    mem_write   = 1'b1;
                    mem_address = {line_tag, index};
                    if (!mem_busywait) begin
                        clean_en   = 1'b1;
                        next_state = FETCH;
                    end
                end
                FETCH: begin
                    BUSYWAIT = 1'b1;
                    mem_read = 1'b1;
                    if (!mem_busywait) begin
                        fill_en    = 1'b1;
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

`ifdef DCACHE_PERF_EN
    logic missed;
    logic done;

    assign done = !RESET && (state == IDLE) && access && hit;

    // missed remembers that the access now completing had to go to memory first.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            missed     <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (state == IDLE && next_state != IDLE) begin
                missed <= 1'b1;
                if (miss_count != '1) miss_count <= miss_count + 1'b1;
            end
            if (done) begin
                missed <= 1'b0;
                if (!missed && hit_count != '1) hit_count <= hit_count + 1'b1;
            end
            if (state == WRITEBACK && next_state == FETCH && wb_count != '1)
                wb_count <= wb_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_param_dcache.sv
// tb/tb_param_dcache.sv - scoreboard bench for param_dcache with a multi-cycle memory model
module tb_param_dcache;

    localparam int TMEM = 5;

    typedef struct {
        bit         is_read;
        logic [7:0] data;
        int         stall;
    } cpu_exp_t;

    typedef struct {
        bit          is_write;
        logic [5:0]  addr;
        logic [31:0] data;
    } mem_exp_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;
`ifdef DCACHE_PERF_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    logic [15:0] wb_count;
`endif

    always #5 CLK = ~CLK;

    param_dcache dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
`ifdef DCACHE_PERF_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count),
        .wb_count      (wb_count)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory device: busy for TMEM-1 cycles of a request, plus one recovery cycle after an accept.
    logic [31:0] dev_mem [64];
    int          cnt     = 0;
    bit          recover = 1'b0;
    bit          acc_n   = 1'b0;

    assign mem_readdata = dev_mem[mem_address];
    assign mem_busywait = (mem_read || mem_write) && (recover || cnt < TMEM - 1);

    always @(posedge CLK) begin
        if (acc_n) begin
            cnt     <= 0;
            recover <= 1'b1;
        end else begin
            recover <= 1'b0;
            if (!(mem_read || mem_write)) cnt <= 0;
            else if (!recover)            cnt <= cnt + 1;
        end
    end

    // Reference model: plain arrays of lines and a word-addressed backing store.
    logic [7:0] ref_mem [256];
    bit         m_valid [8];
    bit         m_dirty [8];
    logic [2:0] m_tag   [8];
    logic [7:0] m_data  [8][4];
    int         m_hits   = 0;
    int         m_misses = 0;
    int         m_wbs    = 0;

    cpu_exp_t cpu_q[$];
    mem_exp_t mem_q[$];

    task automatic model_writeback(input logic [2:0] i);
        mem_exp_t me;
        me.is_write = 1'b1;
        me.addr     = {m_tag[i], i};
        me.data     = {m_data[i][3], m_data[i][2], m_data[i][1], m_data[i][0]};
        mem_q.push_back(me);
        for (int k = 0; k < 4; k++) ref_mem[{m_tag[i], i, 2'(k)}] = m_data[i][k];
        m_wbs++;
    endtask

    task automatic model_access(input bit r, input bit w, input logic [7:0] a, input logic [7:0] d);
        logic [2:0] t, i;
        logic [1:0] o;
        cpu_exp_t   ce;
        mem_exp_t   me;
        int         stall;
        t = a[7:5];
        i = a[4:2];
        o = a[1:0];
        if (m_valid[i] && m_tag[i] == t) begin
            stall = 0;
            m_hits++;
        end else begin
            m_misses++;
            stall = TMEM + 1;
            if (m_valid[i] && m_dirty[i]) begin
                model_writeback(i);
                stall = 2 * TMEM + 2;
            end
            me.is_write = 1'b0;
            me.addr     = {t, i};
            me.data     = '0;
            mem_q.push_back(me);
            for (int k = 0; k < 4; k++) m_data[i][k] = ref_mem[{t, i, 2'(k)}];
            m_valid[i] = 1'b1;
            m_dirty[i] = 1'b0;
            m_tag[i]   = t;
        end
        ce.is_read = r;
        ce.data    = m_data[i][o];
        ce.stall   = stall;
        cpu_q.push_back(ce);
        if (w) begin
            m_data[i][o] = d;
            m_dirty[i]   = 1'b1;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_hits   = 0;
        m_misses = 0;
        m_wbs    = 0;
    endtask

    // CPU-side monitor: counts stall cycles and scores each completed access.
    int stall_cnt = 0;

    task automatic score_cpu(input int stalls);
        cpu_exp_t ce;
        if (cpu_q.size() == 0) begin
            check("cpu_unexpected_completion", 32'd1, 32'd0);
        end else begin
            ce = cpu_q.pop_front();
            check("stall_cycles", stalls, ce.stall);
            if (ce.is_read) check("readdata", {24'd0, READDATA}, {24'd0, ce.data});
        end
    endtask

    always @(negedge CLK) begin
        if (RESET) begin
            stall_cnt <= 0;
        end else if (READ || WRITE) begin
            if (BUSYWAIT) begin
                stall_cnt <= stall_cnt + 1;
            end else begin
                score_cpu(stall_cnt);
                stall_cnt <= 0;
            end
        end
    end

    // Memory-side monitor: scores each accepted transfer and performs write-backs.
    task automatic score_mem();
        mem_exp_t me;
        if (mem_q.size() == 0) begin
            check("mem_unexpected_transfer", 32'd1, 32'd0);
        end else begin
            me = mem_q.pop_front();
            check("mem_is_write", {31'd0, mem_write}, {31'd0, me.is_write});
            check("mem_address", {26'd0, mem_address}, {26'd0, me.addr});
            if (me.is_write) check("mem_writedata", mem_writedata, me.data);
        end
    endtask

    always @(negedge CLK) begin
        if (mem_read || mem_write) check("mem_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
        if ((mem_read || mem_write) && !mem_busywait) begin
            score_mem();
            if (mem_write) dev_mem[mem_address] <= mem_writedata;
            acc_n <= 1'b1;
        end else begin
            acc_n <= 1'b0;
        end
    end

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge CLK);
            if (!BUSYWAIT) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL access_timeout: got busy expected done at %0t", $time);
        end
        @(posedge CLK);
        #1;
        READ  = 1'b0;
        WRITE = 1'b0;
    endtask

    task automatic do_access(input bit r, input bit w, input logic [7:0] a, input logic [7:0] d);
        model_access(r, w, a, d);
        READ      = r;
        WRITE     = w;
        ADDRESS   = a;
        WRITEDATA = d;
        wait_done();
    endtask

    task automatic reset_during_fetch(input logic [7:0] a);
        bit seen;
        logic [2:0] i;
        i = a[4:2];
        seen = 1'b0;
        if (m_valid[i] && m_tag[i] != a[7:5] && m_dirty[i]) model_writeback(i);
        READ    = 1'b1;
        WRITE   = 1'b0;
        ADDRESS = a;
        for (int n = 0; n < 100; n++) begin
            @(negedge CLK);
            if (mem_read) begin
                seen = 1'b1;
                break;
            end
        end
        check("fetch_started", {31'd0, seen}, 32'd1);
        @(posedge CLK);
        #1 RESET = 1'b1;
        @(posedge CLK);
        #1 RESET = 1'b0;
        model_reset();
        model_access(1'b1, 1'b0, a, 8'h00);
        @(negedge CLK);
        check("abort_mem_read", {31'd0, mem_read}, 32'd0);
        check("abort_rereads_miss", {31'd0, BUSYWAIT}, 32'd1);
        wait_done();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish by %0t", $time);
        bad++;
        total++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        int op;
        logic [7:0] a;
        RESET     = 1'b1;
        READ      = 1'b1;
        WRITE     = 1'b0;
        ADDRESS   = 8'h05;
        WRITEDATA = 8'h00;
        for (int b = 0; b < 64; b++) begin
            w = $urandom;
            if (b == 1) w = 32'h44332211;
            dev_mem[b] = w;
            for (int k = 0; k < 4; k++) ref_mem[b*4 + k] = w[k*8 +: 8];
        end
        model_reset();

        @(negedge CLK);
        @(negedge CLK);
        check("reset_busywait", {31'd0, BUSYWAIT}, 32'd0);
        check("reset_mem_read", {31'd0, mem_read}, 32'd0);
        check("reset_mem_write", {31'd0, mem_write}, 32'd0);
        check("reset_readdata", {24'd0, READDATA}, 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        READ  = 1'b0;

        do_access(1'b1, 1'b0, 8'h05, 8'h00);
        do_access(1'b1, 1'b0, 8'h07, 8'h00);
        do_access(1'b0, 1'b1, 8'h05, 8'hAA);
        do_access(1'b1, 1'b0, 8'h25, 8'h00);
        check("writeback_block", dev_mem[1], 32'h4433AA11);

        do_access(1'b1, 1'b1, 8'h25, 8'h5A);
        do_access(1'b1, 1'b0, 8'h25, 8'h00);

        reset_during_fetch(8'h45);
        do_access(1'b1, 1'b0, 8'h46, 8'h00);

        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 2);
            a  = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            do_access(op != 1, op != 0, a, 8'($urandom));
        end

        repeat (3) @(posedge CLK);
        check("cpu_queue_drained", cpu_q.size(), 32'd0);
        check("mem_queue_drained", mem_q.size(), 32'd0);
`ifdef DCACHE_PERF_EN
        @(negedge CLK);
        check("hit_count", hit_count, m_hits);
        check("miss_count", miss_count, m_misses);
        check("wb_count", {16'd0, wb_count}, m_wbs);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
